// File: rtl/ps2_host_tx_if.sv
// Command-byte request/status bundle between a PS/2 host controller and ps2_host_tx.
// The master raises requests and watches status; the slave is the transmitter.
interface ps2_host_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       done;
   logic       ack_err;
   logic       timeout;

   modport master (output tx_data, tx_valid,
                   input  tx_ready, busy, done, ack_err, timeout);
   modport slave  (input  tx_data, tx_valid,
                   output tx_ready, busy, done, ack_err, timeout);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start bit, 8 data LSB first, odd parity, stop, ACK.
// Define PS2_TX_AUTO_RETRY_EN to retry a failed frame once before reporting ack_err/timeout.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic         clk,
   input  logic         rst,
   ps2_host_tx_if.slave tx,
   input  logic         ps2_clk,
   input  logic         ps2_data,
   output logic         ps2_clk_oe,
   output logic         ps2_data_oe,
   output logic [2:0]   state_dbg
);

   localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
`ifdef PS2_TX_AUTO_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INHIBIT = 3'd1,
      S_SEND    = 3'd2,
      S_ACK     = 3'd3,
      S_WAIT    = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [INH_W-1:0] inh_q, inh_d;
   logic [3:0]       bit_q, bit_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic [7:0]       byte_q, byte_d;
   logic             data_oe_q, data_oe_d;
   logic             clk_oe_q, clk_oe_d;
   logic             nack_q, nack_d;
   logic             retry_q, retry_d;
   logic             done_q, done_d;
   logic             ack_err_q, ack_err_d;
   logic             timeout_q, timeout_d;
   logic             fail_to, fail_nack;

   logic clk_s1, clk_s2, clk_prev;
   logic data_s1, data_s2;
   logic fe, accept;

   // Lines idle high, so synchronizers come out of reset as an idle bus.
   always_ff @(posedge clk) begin
      if (!rst) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         data_s1  <= 1'b1;
         data_s2  <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         data_s1  <= ps2_data;
         data_s2  <= data_s1;
      end
   end

   assign fe = clk_prev & ~clk_s2;

   // Handshake: tx_data is taken on a cycle where tx_valid && tx_ready; tx_ready is high
   // only in IDLE with both lines idle, and a held tx_valid simply waits for the next frame.
   assign tx.tx_ready = (state_q == S_IDLE) && clk_s2 && data_s2;
   assign accept      = tx.tx_valid && tx.tx_ready;
   assign tx.busy     = (state_q != S_IDLE);
   assign tx.done     = done_q;
   assign tx.ack_err  = ack_err_q;
   assign tx.timeout  = timeout_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign state_dbg   = state_q;

   always_comb begin
      state_d   = state_q;
      inh_d     = inh_q;
      bit_d     = bit_q;
      to_d      = to_q;
      byte_d    = byte_q;
      data_oe_d = data_oe_q;
      nack_d    = nack_q;
      retry_d   = retry_q;
      done_d    = 1'b0;
      ack_err_d = 1'b0;
      timeout_d = 1'b0;
      fail_to   = 1'b0;
      fail_nack = 1'b0;

      case (state_q)
         S_IDLE: begin
            inh_d     = '0;
            bit_d     = '0;
            to_d      = '0;
            nack_d    = 1'b0;
            retry_d   = 1'b0;
            data_oe_d = 1'b0;
            if (accept) begin
               byte_d    = tx.tx_data;
               state_d   = S_INHIBIT;
               data_oe_d = (INHIBIT_CYCLES == 1);
            end
         end
         S_INHIBIT: begin
            inh_d = inh_q + 1'b1;
            // Start bit is pulled low during the final inhibit cycle.
            if (INHIBIT_CYCLES >= 2 && inh_q == INH_PRE) data_oe_d = 1'b1;
            if (inh_q == INH_LAST) begin
               state_d   = S_SEND;
               inh_d     = '0;
               bit_d     = '0;
               to_d      = '0;
               data_oe_d = 1'b1;
            end
         end
         S_SEND: begin
            to_d = to_q + 1'b1;
            if (fe) begin
               to_d  = '0;
               bit_d = bit_q + 4'd1;
               if (bit_q < 4'd8) begin
                  data_oe_d = ~byte_q[bit_q[2:0]];
               end else if (bit_q == 4'd8) begin
                  data_oe_d = ^byte_q;
               end else begin
                  data_oe_d = 1'b0;
                  state_d   = S_ACK;
               end
            end else if (to_q == TO_LAST) begin
               fail_to = 1'b1;
            end
         end
         S_ACK: begin
            to_d = to_q + 1'b1;
            if (fe) begin
               to_d = '0;
               if (data_s2) fail_nack = 1'b1;
               else         state_d   = S_WAIT;
            end else if (to_q == TO_LAST) begin
               fail_to = 1'b1;
            end
         end
         S_WAIT: begin
            to_d = to_q + 1'b1;
            if (clk_s2 && data_s2) begin
               done_d  = ~nack_q;
               state_d = S_IDLE;
            end else if (to_q == TO_LAST) begin
               fail_to = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (fail_to || fail_nack) begin
         if (RETRY_EN && !retry_q) begin
            retry_d   = 1'b1;
            state_d   = S_INHIBIT;
            inh_d     = '0;
            bit_d     = '0;
            to_d      = '0;
            data_oe_d = (INHIBIT_CYCLES == 1);
         end else if (fail_to) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
            data_oe_d = 1'b0;
         end else begin
            // A NACK still lets the device finish its clocking before we return to IDLE.
            ack_err_d = 1'b1;
            nack_d    = 1'b1;
            state_d   = S_WAIT;
            to_d      = '0;
         end
      end

      clk_oe_d = (state_d == S_INHIBIT);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         inh_q     <= '0;
         bit_q     <= '0;
         to_q      <= '0;
         byte_q    <= '0;
         data_oe_q <= 1'b0;
         clk_oe_q  <= 1'b0;
         nack_q    <= 1'b0;
         retry_q   <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         inh_q     <= inh_d;
         bit_q     <= bit_d;
         to_q      <= to_d;
         byte_q    <= byte_d;
         data_oe_q <= data_oe_d;
         clk_oe_q  <= clk_oe_d;
         nack_q    <= nack_d;
         retry_q   <= retry_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: an open-drain PS/2 device model clocking at 1/20 clk,
// frames scored against an expected queue filled when each byte is offered.
module tb_ps2_host_tx;
   localparam int INH  = 8;
   localparam int TO   = 200;
   localparam int HALF = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ps2_host_tx_if bus ();
   logic       ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe;
   logic [2:0] state_dbg;
   logic       dev_clk_low  = 1'b0;
   logic       dev_data_low = 1'b0;

   assign ps2_clk  = ~(ps2_clk_oe  | dev_clk_low);
   assign ps2_data = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .tx          (bus),
      .ps2_clk     (ps2_clk),
      .ps2_data    (ps2_data),
      .ps2_clk_oe  (ps2_clk_oe),
      .ps2_data_oe (ps2_data_oe),
      .state_dbg   (state_dbg)
   );

   int total = 0;
   int bad   = 0;
   int cyc = 0, done_cnt = 0, ack_err_cnt = 0, timeout_cnt = 0;
   int clk_oe_cyc = 0, accept_cnt = 0, done_at_accept = 0, fe_cyc = 0;
   logic [10:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [10:0] frame_of(input logic [7:0] b);
      return {1'b1, ~^b, b, 1'b0};
   endfunction

   always @(negedge clk) begin
      cyc++;
      if (bus.done)    done_cnt++;
      if (bus.ack_err) ack_err_cnt++;
      if (bus.timeout) timeout_cnt++;
      if (ps2_clk_oe)  clk_oe_cyc++;
      if (rst && bus.tx_valid && bus.tx_ready) begin
         accept_cnt++;
         done_at_accept = done_cnt;
      end
   end

   task automatic wait_ready();
      int w = 0;
      while (!bus.tx_ready && w < 1000) begin @(negedge clk); w++; end
      if (w >= 1000) check("ready_wait", 0, 1);
   endtask

   task automatic wait_idle();
      int w = 0;
      while ((bus.busy || !bus.tx_ready) && w < 2000) begin @(negedge clk); w++; end
      if (w >= 2000) check("idle_wait", 0, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit push);
      wait_ready();
      @(posedge clk); #1;
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      if (push) exp_q.push_back(frame_of(b));
      @(posedge clk); #1;
      bus.tx_valid = 1'b0;
   endtask

   // Device side: sample start before clocking, bits at rising edges, ACK at the 11th falling edge.
   task automatic device_run(input int n_fe, input bit ack_low, input bit chk);
      logic [10:0] frame;
      logic [10:0] exp;
      int w = 0;
      frame = '0;
      while (!(bus.busy && !ps2_clk_oe && ps2_data_oe) && w < 600) begin @(negedge clk); w++; end
      if (w >= 600) begin
         check("dev_start_wait", 0, 1);
         return;
      end
      frame[0] = ps2_data;
      repeat (HALF) @(negedge clk);
      for (int i = 1; i <= 11; i++) begin
         if (i > n_fe) break;
         dev_clk_low = 1'b1;
         fe_cyc = cyc;
         repeat (HALF) @(negedge clk);
         dev_clk_low = 1'b0;
         if (i <= 10) frame[i] = ps2_data;
         if (i == 10) dev_data_low = ack_low;
         repeat (HALF) @(negedge clk);
      end
      dev_data_low = 1'b0;
      if (chk) begin
         if (exp_q.size() == 0) check("sb_empty", 0, 1);
         else begin
            exp = exp_q.pop_front();
            check("frame", frame, exp);
         end
      end
   endtask

   task automatic run_frame(input logic [7:0] b);
      int d0, a0, t0;
      d0 = done_cnt; a0 = ack_err_cnt; t0 = timeout_cnt;
      clk_oe_cyc = 0;
      send_byte(b, 1'b1);
      device_run(11, 1'b1, 1'b1);
      wait_idle();
      check("done", done_cnt - d0, 1);
      check("ack_err", ack_err_cnt - a0, 0);
      check("timeout", timeout_cnt - t0, 0);
      check("clk_oe_cycles", clk_oe_cyc, INH);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog got=stuck exp=finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, a0, t0, acc0, lat, w;
      bus.tx_data  = 8'h00;
      bus.tx_valid = 1'b0;
      rst = 1'b0;
      repeat (4) @(posedge clk); #1;
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_data_oe", ps2_data_oe, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_pulses", {bus.done, bus.ack_err, bus.timeout}, 0);
      check("rst_state", state_dbg, 0);
      @(negedge clk); rst = 1'b1;
      repeat (4) @(negedge clk);
      check("rst_ready", bus.tx_ready, 1);

      // Command bytes with differing parity.
      run_frame(8'hED);
      run_frame(8'h01);
      run_frame(8'hFF);

      // Device leaves data high at the ACK edge.
      d0 = done_cnt; a0 = ack_err_cnt; t0 = timeout_cnt;
`ifdef PS2_TX_AUTO_RETRY_EN
      send_byte(8'hF4, 1'b1);
      exp_q.push_back(frame_of(8'hF4));
      device_run(11, 1'b0, 1'b1);
      device_run(11, 1'b1, 1'b1);
      wait_idle();
      check("retry_done", done_cnt - d0, 1);
      check("retry_ack_err", ack_err_cnt - a0, 0);
`else
      send_byte(8'hF4, 1'b1);
      device_run(11, 1'b0, 1'b1);
      wait_idle();
      check("nack_done", done_cnt - d0, 0);
      check("nack_ack_err", ack_err_cnt - a0, 1);
`endif
      check("nack_timeout", timeout_cnt - t0, 0);

      // Device stops clocking after the fourth falling edge.
      d0 = done_cnt; a0 = ack_err_cnt; t0 = timeout_cnt;
      send_byte(8'h3C, 1'b0);
      device_run(4, 1'b1, 1'b0);
`ifdef PS2_TX_AUTO_RETRY_EN
      device_run(4, 1'b1, 1'b0);
`endif
      w = 0;
      while (timeout_cnt == t0 && w < 600) begin @(negedge clk); w++; end
      if (w >= 600) check("timeout_wait", 0, 1);
      lat = cyc - fe_cyc;
      check("timeout_latency_ok", (lat >= TO + 1 && lat <= TO + 6), 1);
      check("to_clk_oe", ps2_clk_oe, 0);
      check("to_data_oe", ps2_data_oe, 0);
      repeat (4) @(negedge clk);
      check("to_ready", bus.tx_ready, 1);
      check("to_count", timeout_cnt - t0, 1);
      check("to_no_done", (done_cnt - d0) + (ack_err_cnt - a0), 0);

      // Reset in the middle of the data bits.
      d0 = done_cnt; a0 = ack_err_cnt; t0 = timeout_cnt;
      send_byte(8'h00, 1'b0);
      device_run(2, 1'b1, 1'b0);
      check("pre_rst_data_oe", ps2_data_oe, 1);
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrst_clk_oe", ps2_clk_oe, 0);
      check("midrst_data_oe", ps2_data_oe, 0);
      check("midrst_busy", bus.busy, 0);
      @(negedge clk); rst = 1'b1;
      repeat (TO + 100) @(negedge clk);
      check("midrst_pulses", (done_cnt - d0) + (ack_err_cnt - a0) + (timeout_cnt - t0), 0);
      check("midrst_ready", bus.tx_ready, 1);

      // tx_valid held across a frame: the second byte waits for done.
      d0 = done_cnt; a0 = ack_err_cnt;
      wait_ready();
      acc0 = accept_cnt;
      @(posedge clk); #1;
      bus.tx_data  = 8'hA5;
      bus.tx_valid = 1'b1;
      exp_q.push_back(frame_of(8'hA5));
      exp_q.push_back(frame_of(8'h55));
      fork
         begin
            device_run(11, 1'b1, 1'b1);
            device_run(11, 1'b1, 1'b1);
         end
         begin
            @(posedge clk); #1;
            bus.tx_data = 8'h55;
            w = 0;
            while (accept_cnt < acc0 + 2 && w < 3000) begin @(negedge clk); w++; end
            if (w >= 3000) check("accept2_wait", 0, 1);
            @(posedge clk); #1;
            bus.tx_valid = 1'b0;
         end
      join
      wait_idle();
      check("held_accepts", accept_cnt - acc0, 2);
      check("held_after_done", done_at_accept - d0, 1);
      check("held_done", done_cnt - d0, 2);
      check("held_ack_err", ack_err_cnt - a0, 0);
      check("sb_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
